// File: rtl/ddr3_pkg.sv
// Shared command encodings, queue field layout and command predicates for the DDR3 controller.
package ddr3_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_SCR  = 3'd1,
        CMD_SCW  = 3'd2,
        CMD_BLR  = 3'd3,
        CMD_BLW  = 3'd4,
        CMD_ATR  = 3'd5,
        CMD_ATW  = 3'd6,
        CMD_RSVD = 3'd7
    } cmd_e;

    localparam int unsigned CMD_W = 3;
    localparam int unsigned SZ_W  = 2;
    localparam int unsigned OP_W  = 3;

    // Command queue entry is {id, cmd, addr, sz, op}, op in the LSBs.
    localparam int unsigned CQ_OP_LSB   = 0;
    localparam int unsigned CQ_SZ_LSB   = CQ_OP_LSB + OP_W;
    localparam int unsigned CQ_ADDR_LSB = CQ_SZ_LSB + SZ_W;

    function automatic int unsigned cq_cmd_lsb(input int unsigned aw);
        return CQ_ADDR_LSB + aw;
    endfunction

    function automatic int unsigned cq_id_lsb(input int unsigned aw);
        return CQ_ADDR_LSB + aw + CMD_W;
    endfunction

    function automatic int unsigned id_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic logic is_valid_cmd(input logic [2:0] c);
        return (c != CMD_IDLE) && (c != CMD_RSVD);
    endfunction

    // Commands whose first write beat travels with the command.
    function automatic logic is_data_cmd(input logic [2:0] c);
        return (c == CMD_SCW) || (c == CMD_BLW) || (c == CMD_ATR) || (c == CMD_ATW);
    endfunction

endpackage

// File: rtl/ddr3_fifo.sv
// Codebase synchronous FIFO: power-of-two depth, output read from the head register.
module ddr3_fifo #(
    parameter int unsigned W        = 8,
    parameter int unsigned DEPTH_P2 = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                put,
    input  logic [W-1:0]        din,
    input  logic                get,
    output logic [W-1:0]        dout,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_P2:0]   fillcount
);

    localparam int unsigned DEPTH = 1 << DEPTH_P2;
    localparam int unsigned CW    = DEPTH_P2 + 1;

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_P2-1:0]   wr_ptr;
    logic [DEPTH_P2-1:0]   rd_ptr;
    logic                  do_put;
    logic                  do_get;

    assign empty  = (fillcount == '0);
    assign full   = (fillcount == CW'(DEPTH));
    assign do_put = put & ~full;
    assign do_get = get & ~empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_put) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fillcount <= '0;
        end else begin
            if (do_put) wr_ptr <= wr_ptr + 1'b1;
            if (do_get) rd_ptr <= rd_ptr + 1'b1;
            if (do_put && !do_get)      fillcount <= fillcount + 1'b1;
            else if (!do_put && do_get) fillcount <= fillcount - 1'b1;
        end
    end

endmodule

// File: rtl/frontend_rr_arbiter.sv
// Round-robin arbiter: first request at or after rr_ptr wins, wrapping modulo NCH.
module frontend_rr_arbiter #(
    parameter int unsigned NCH = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IDW-1:0] rr_ptr,
    input  logic           enable,
    output logic [NCH-1:0] grant,
    output logic [IDW-1:0] winner,
    output logic           valid
);

    int unsigned idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                winner     = IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
        if (!enable) begin
            valid = 1'b0;
            grant = '0;
        end
    end

endmodule

// File: rtl/ddr3_multiport_frontend.sv
// Multi-port command/data admission: round-robin over NCH hosts into shared command and write-data queues.
module ddr3_multiport_frontend
    import ddr3_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned AW         = 26,
    parameter int unsigned DW         = 16,
    parameter int unsigned DEPTH_P2   = 5,
    parameter int unsigned BURST_UNIT = 8,
    localparam int unsigned IDW       = id_width(NCH),
    localparam int unsigned CQW       = IDW + CMD_W + AW + SZ_W + OP_W,
    localparam int unsigned DQW       = IDW + DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready,
    input  logic [NCH*3-1:0]     ch_cmd,
    input  logic [NCH*AW-1:0]    ch_addr,
    input  logic [NCH*2-1:0]     ch_sz,
    input  logic [NCH*3-1:0]     ch_op,
    input  logic [NCH*DW-1:0]    ch_din,
    input  logic [NCH-1:0]       ch_din_valid,
    output logic [NCH-1:0]       ch_accept,
    output logic [NCH-1:0]       ch_data_ready,
    input  logic                 cq_get,
    output logic [CQW-1:0]       cq_data,
    output logic                 cq_empty,
    output logic [DEPTH_P2:0]    cq_fillcount,
    input  logic                 dq_get,
    output logic [DQW-1:0]       dq_data,
    output logic                 dq_empty,
    output logic [DEPTH_P2:0]    dq_fillcount,
    output logic                 burst_busy,
    output logic [IDW-1:0]       burst_owner
);

    localparam int unsigned BCW = $clog2(4 * BURST_UNIT);

    logic [CMD_W-1:0] cmd_a  [NCH];
    logic [AW-1:0]    addr_a [NCH];
    logic [SZ_W-1:0]  sz_a   [NCH];
    logic [OP_W-1:0]  op_a   [NCH];
    logic [DW-1:0]    din_a  [NCH];
    logic [NCH-1:0]   req;

    logic [IDW-1:0]   rr_ptr;
    logic [BCW-1:0]   beat_cnt;
    logic [BCW-1:0]   burst_init;

    logic [NCH-1:0]   grant;
    logic [IDW-1:0]   winner;
    logic             arb_valid;
    logic             arb_enable;
    logic [CMD_W-1:0] win_cmd;
    logic             win_data;
    logic             admit;
    logic             beat_take;

    logic             cq_full;
    logic             dq_full;
    logic             cq_put;
    logic             dq_put;
    logic [CQW-1:0]   cq_din;
    logic [DQW-1:0]   dq_din;

    // Unpack the flat per-channel buses.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            cmd_a[i]  = ch_cmd[i*3 +: 3];
            addr_a[i] = ch_addr[i*AW +: AW];
            sz_a[i]   = ch_sz[i*2 +: 2];
            op_a[i]   = ch_op[i*3 +: 3];
            din_a[i]  = ch_din[i*DW +: DW];
            req[i]    = is_valid_cmd(ch_cmd[i*3 +: 3]);
        end
    end

    assign arb_enable = ready & ~burst_busy & ~cq_full;

    frontend_rr_arbiter #(
        .NCH (NCH),
        .IDW (IDW)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .enable (arb_enable),
        .grant  (grant),
        .winner (winner),
        .valid  (arb_valid)
    );

    // A data-carrying winner is held off by a full data queue; lower-priority requesters wait too.
    assign win_cmd    = cmd_a[winner];
    assign win_data   = is_data_cmd(win_cmd);
    assign admit      = arb_valid & (~win_data | ~dq_full);
    assign beat_take  = burst_busy & ch_din_valid[burst_owner] & ~dq_full;
    assign burst_init = BCW'((32'(sz_a[winner]) + 32'd1) * BURST_UNIT - 32'd1);

    always_comb begin
        ch_accept     = admit ? grant : '0;
        ch_data_ready = '0;
        if (burst_busy) ch_data_ready[burst_owner] = ~dq_full;
    end

    assign cq_put = admit;
    assign cq_din = {winner, win_cmd, addr_a[winner], sz_a[winner], op_a[winner]};
    assign dq_put = (admit & win_data) | beat_take;
    assign dq_din = burst_busy ? {burst_owner, din_a[burst_owner]} : {winner, din_a[winner]};

    // Round-robin pointer and burst-write lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            burst_busy  <= 1'b0;
            burst_owner <= '0;
            beat_cnt    <= '0;
        end else if (admit) begin
            rr_ptr <= (winner == IDW'(NCH - 1)) ? '0 : winner + 1'b1;
            if (win_cmd == CMD_BLW) begin
                burst_busy  <= (burst_init != '0);
                burst_owner <= winner;
                beat_cnt    <= burst_init;
            end
        end else if (beat_take) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == BCW'(1)) burst_busy <= 1'b0;
        end
    end

    ddr3_fifo #(
        .W        (CQW),
        .DEPTH_P2 (DEPTH_P2)
    ) u_cq (
        .clk       (clk),
        .reset     (reset),
        .put       (cq_put),
        .din       (cq_din),
        .get       (cq_get),
        .dout      (cq_data),
        .empty     (cq_empty),
        .full      (cq_full),
        .fillcount (cq_fillcount)
    );

    ddr3_fifo #(
        .W        (DQW),
        .DEPTH_P2 (DEPTH_P2)
    ) u_dq (
        .clk       (clk),
        .reset     (reset),
        .put       (dq_put),
        .din       (dq_din),
        .get       (dq_get),
        .dout      (dq_data),
        .empty     (dq_empty),
        .full      (dq_full),
        .fillcount (dq_fillcount)
    );

endmodule

// File: tb/tb_ddr3_multiport_frontend.sv
// Directed bench for ddr3_multiport_frontend: arbitration table plus burst, full-queue and reset sequences.
module tb_ddr3_multiport_frontend;
    import ddr3_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned AW = 26;
    localparam int unsigned DW = 16;
    localparam int unsigned DEPTH_P2 = 5;
    localparam int unsigned BURST_UNIT = 8;
    localparam int unsigned IDW = 2;
    localparam int unsigned CQW = IDW + 3 + AW + 2 + 3;
    localparam int unsigned DQW = IDW + DW;

    logic clk = 1'b0;
    logic reset;
    logic ready;
    logic [NCH*3-1:0] ch_cmd;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*2-1:0] ch_sz;
    logic [NCH*3-1:0] ch_op;
    logic [NCH*DW-1:0] ch_din;
    logic [NCH-1:0] ch_din_valid;
    logic [NCH-1:0] ch_accept;
    logic [NCH-1:0] ch_data_ready;
    logic cq_get;
    logic [CQW-1:0] cq_data;
    logic cq_empty;
    logic [DEPTH_P2:0] cq_fillcount;
    logic dq_get;
    logic [DQW-1:0] dq_data;
    logic dq_empty;
    logic [DEPTH_P2:0] dq_fillcount;
    logic burst_busy;
    logic [IDW-1:0] burst_owner;

    ddr3_multiport_frontend #(
        .NCH(NCH), .AW(AW), .DW(DW), .DEPTH_P2(DEPTH_P2), .BURST_UNIT(BURST_UNIT)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .ch_cmd(ch_cmd), .ch_addr(ch_addr), .ch_sz(ch_sz), .ch_op(ch_op),
        .ch_din(ch_din), .ch_din_valid(ch_din_valid),
        .ch_accept(ch_accept), .ch_data_ready(ch_data_ready),
        .cq_get(cq_get), .cq_data(cq_data), .cq_empty(cq_empty), .cq_fillcount(cq_fillcount),
        .dq_get(dq_get), .dq_data(dq_data), .dq_empty(dq_empty), .dq_fillcount(dq_fillcount),
        .burst_busy(burst_busy), .burst_owner(burst_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [11:0] cmd;
        logic [3:0]  acc;
    } vec_t;

    vec_t vt [8];
    logic [CQW-1:0] exp_q [$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] addr_of(input int unsigned ch);
        return AW'(32'h0012_3400 + ch);
    endfunction

    function automatic logic [CQW-1:0] cq_exp(input int unsigned ch, input logic [2:0] c, input logic [1:0] sz);
        return {IDW'(ch), c, addr_of(ch), sz, 3'(ch)};
    endfunction

    task automatic set_ch(input int unsigned ch, input logic [2:0] c, input logic [1:0] sz);
        ch_cmd[ch*3 +: 3] = c;
        ch_sz[ch*2 +: 2] = sz;
    endtask

    task automatic idle_all();
        ch_cmd = '0;
        ch_sz = '0;
        ch_din_valid = '0;
        cq_get = 1'b0;
        dq_get = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic pop_cq(input string name, input logic [CQW-1:0] exp);
        check(name, 64'(cq_data), 64'(exp));
        cq_get = 1'b1;
        cyc();
        cq_get = 1'b0;
    endtask

    task automatic pop_dq(input string name, input logic [DQW-1:0] exp);
        check(name, 64'(dq_data), 64'(exp));
        dq_get = 1'b1;
        cyc();
        dq_get = 1'b0;
    endtask

    initial begin
        ready = 1'b1;
        ch_addr = '0;
        ch_op = '0;
        ch_din = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_addr[i*AW +: AW] = addr_of(i);
            ch_op[i*3 +: 3] = 3'(i);
            ch_din[i*DW +: DW] = DW'(16'h1000 * (i + 1));
        end
        @(negedge clk);
        do_reset();

        // Reset state
        #1;
        check("rst cq_empty", 64'(cq_empty), 64'(1));
        check("rst dq_empty", 64'(dq_empty), 64'(1));
        check("rst cq_fill", 64'(cq_fillcount), 64'(0));
        check("rst dq_fill", 64'(dq_fillcount), 64'(0));
        check("rst busy", 64'(burst_busy), 64'(0));
        check("rst owner", 64'(burst_owner), 64'(0));
        check("rst accept", 64'(ch_accept), 64'(0));
        check("rst data_ready", 64'(ch_data_ready), 64'(0));

        // Arbitration table: {ch3,ch2,ch1,ch0} commands; rr_ptr starts at 0
        vt[0] = '{1'b0, {3'd0, 3'd1, 3'd0, 3'd1}, 4'b0000};
        vt[1] = '{1'b1, {3'd0, 3'd1, 3'd0, 3'd1}, 4'b0001};
        vt[2] = '{1'b1, {3'd0, 3'd1, 3'd0, 3'd0}, 4'b0100};
        vt[3] = '{1'b1, {3'd0, 3'd0, 3'd7, 3'd0}, 4'b0000};
        vt[4] = '{1'b1, {3'd1, 3'd0, 3'd1, 3'd1}, 4'b1000};
        vt[5] = '{1'b1, {3'd0, 3'd0, 3'd1, 3'd1}, 4'b0001};
        vt[6] = '{1'b1, {3'd0, 3'd0, 3'd1, 3'd0}, 4'b0010};
        vt[7] = '{1'b1, {3'd0, 3'd0, 3'd0, 3'd3}, 4'b0001};
        for (int v = 0; v < 8; v++) begin
            ready = vt[v].rdy;
            ch_cmd = vt[v].cmd;
            #1;
            check($sformatf("vec%0d accept", v), 64'(ch_accept), 64'(vt[v].acc));
            for (int unsigned c = 0; c < NCH; c++)
                if (vt[v].acc[c]) exp_q.push_back(cq_exp(c, vt[v].cmd[c*3 +: 3], 2'd0));
            cyc();
        end
        idle_all();
        ready = 1'b1;
        check("vec cq_fill", 64'(cq_fillcount), 64'(exp_q.size()));
        check("vec dq_empty", 64'(dq_empty), 64'(1));
        while (exp_q.size() > 0) pop_cq("vec cq entry", exp_q.pop_front());
        check("vec cq drained", 64'(cq_empty), 64'(1));

        // BLW on ch1 (16 beats, gapped) with ch3 SCW waiting behind the lock
        do_reset();
        ch_din[1*DW +: DW] = 16'hA000;
        ch_din[3*DW +: DW] = 16'h3333;
        set_ch(1, CMD_BLW, 2'd1);
        set_ch(3, CMD_SCW, 2'd0);
        #1;
        check("blw accept", 64'(ch_accept), 64'(4'b0010));
        cyc();
        set_ch(1, CMD_IDLE, 2'd0);
        check("blw busy", 64'(burst_busy), 64'(1));
        check("blw owner", 64'(burst_owner), 64'(1));
        check("blw dq first", 64'(dq_data), 64'({2'd1, 16'hA000}));
        for (int k = 1; k < 16; k++) begin
            if (k % 4 == 0) begin
                ch_din_valid = '0;
                #1;
                check("blw gap ready", 64'(ch_data_ready), 64'(4'b0010));
                check("blw gap accept", 64'(ch_accept), 64'(0));
                cyc();
            end
            ch_din[1*DW +: DW] = DW'(16'hA000 + k);
            ch_din_valid = 4'b0010;
            #1;
            check("blw busy during", 64'(burst_busy), 64'(1));
            check("blw lock accept", 64'(ch_accept), 64'(0));
            cyc();
        end
        ch_din_valid = '0;
        #1;
        check("blw busy end", 64'(burst_busy), 64'(0));
        check("blw ready end", 64'(ch_data_ready), 64'(0));
        check("scw after burst", 64'(ch_accept), 64'(4'b1000));
        cyc();
        set_ch(3, CMD_IDLE, 2'd0);
        check("blw dq_fill", 64'(dq_fillcount), 64'(17));
        check("blw cq_fill", 64'(cq_fillcount), 64'(2));
        for (int k = 0; k < 16; k++) pop_dq("blw dq beat", {2'd1, DW'(16'hA000 + k)});
        pop_dq("scw dq", {2'd3, 16'h3333});
        pop_cq("blw cq", cq_exp(1, CMD_BLW, 2'd1));
        pop_cq("scw cq", cq_exp(3, CMD_SCW, 2'd0));

        // Command queue full
        do_reset();
        set_ch(0, CMD_SCR, 2'd0);
        for (int i = 0; i < 32; i++) cyc();
        for (int unsigned c = 0; c < NCH; c++) set_ch(c, CMD_SCR, 2'd0);
        #1;
        check("cqfull fill", 64'(cq_fillcount), 64'(32));
        check("cqfull accept", 64'(ch_accept), 64'(0));
        cq_get = 1'b1;
        #1;
        check("cqfull get same cycle", 64'(ch_accept), 64'(0));
        cyc();
        cq_get = 1'b0;
        #1;
        check("cqfull after get", 64'(ch_accept), 64'(4'b0010));
        cyc();

        // Data queue full: fill with a 32-beat BLW on ch0
        do_reset();
        set_ch(0, CMD_BLW, 2'd3);
        #1;
        check("dqfull blw accept", 64'(ch_accept), 64'(4'b0001));
        cyc();
        set_ch(0, CMD_IDLE, 2'd0);
        ch_din_valid = 4'b0001;
        for (int i = 0; i < 31; i++) cyc();
        ch_din_valid = '0;
        check("dqfull fill", 64'(dq_fillcount), 64'(32));
        check("dqfull busy", 64'(burst_busy), 64'(0));
        set_ch(0, CMD_ATW, 2'd0);
        set_ch(1, CMD_SCR, 2'd0);
        #1;
        check("dqfull scr wins", 64'(ch_accept), 64'(4'b0010));
        cyc();
        #1;
        check("dqfull atw blocks", 64'(ch_accept), 64'(0));
        dq_get = 1'b1;
        #1;
        check("dqfull get same cycle", 64'(ch_accept), 64'(0));
        cyc();
        dq_get = 1'b0;
        #1;
        check("dqfull atw after get", 64'(ch_accept), 64'(4'b0001));
        cyc();

        // Reset mid-burst
        do_reset();
        set_ch(2, CMD_BLW, 2'd0);
        #1;
        check("rstb accept", 64'(ch_accept), 64'(4'b0100));
        cyc();
        set_ch(2, CMD_IDLE, 2'd0);
        ch_din_valid = 4'b0100;
        for (int i = 0; i < 4; i++) cyc();
        check("rstb dq 5 beats", 64'(dq_fillcount), 64'(5));
        reset = 1'b1;
        #1;
        check("rstb busy", 64'(burst_busy), 64'(0));
        check("rstb cq_empty", 64'(cq_empty), 64'(1));
        check("rstb dq_empty", 64'(dq_empty), 64'(1));
        check("rstb data_ready", 64'(ch_data_ready), 64'(0));
        ch_din_valid = '0;
        #2;
        reset = 1'b0;
        set_ch(3, CMD_SCR, 2'd0);
        #1;
        check("rstb scr accept", 64'(ch_accept), 64'(4'b1000));
        cyc();
        set_ch(3, CMD_IDLE, 2'd0);
        check("rstb scr id", 64'(cq_data[CQW-1 -: IDW]), 64'(3));
        check("rstb scr entry", 64'(cq_data), 64'(cq_exp(3, CMD_SCR, 2'd0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
